// File: rtl/seq_divider.sv
// ============================================================================
// Module   : seq_divider
// Brief    : Iterative restoring signed/unsigned divider, one quotient bit/clk
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_error,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic [WIDTH-1:0] quo_acc_q, quo_acc_d;
  logic [WIDTH-1:0] mag_m_q, mag_m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_error_q, div_error_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  // Partial remainder stays below |M|, so the trial difference fits in
  // WIDTH+1 bits and its MSB is a reliable sign.
  assign r_shift = {rem_acc_q, quo_acc_q[WIDTH-1]};
  assign trial   = r_shift - {1'b0, mag_m_q};

  always_comb begin
    state_d     = state_q;
    rem_acc_d   = rem_acc_q;
    quo_acc_d   = quo_acc_q;
    mag_m_d     = mag_m_q;
    cnt_d       = cnt_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_error_d = div_error_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quotient_d  = ALL_ONES;
            remainder_d = dividend;
            div_error_d = 1'b1;
            overflow_d  = 1'b0;
            state_d     = S_DONE;
          end else if (is_signed && (dividend == MIN_VAL) && (divisor == ALL_ONES)) begin
            quotient_d  = MIN_VAL;
            remainder_d = '0;
            div_error_d = 1'b0;
            overflow_d  = 1'b1;
            state_d     = S_DONE;
          end else begin
            q_neg_d   = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d   = is_signed & dividend[WIDTH-1];
            quo_acc_d = (is_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
            mag_m_d   = (is_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
            rem_acc_d = '0;
            cnt_d     = CW'(WIDTH);
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_acc_d = trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_acc_d = {quo_acc_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = q_neg_q ? (~quo_acc_q + 1'b1) : quo_acc_q;
        remainder_d = r_neg_q ? (~rem_acc_q + 1'b1) : rem_acc_q;
        div_error_d = 1'b0;
        overflow_d  = 1'b0;
        state_d     = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_acc_q   <= '0;
      quo_acc_q   <= '0;
      mag_m_q     <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_error_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_acc_q   <= rem_acc_d;
      quo_acc_q   <= quo_acc_d;
      mag_m_q     <= mag_m_d;
      cnt_q       <= cnt_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_error_q <= div_error_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_error = div_error_q;
  assign overflow  = overflow_q;

endmodule

`default_nettype wire
